// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, one-cycle ROM read issue, and a tagged prefetch FIFO
// feeding decode over valid/ready. A redirect flushes buffered and in-flight words.
module instr_fetch #(
   parameter int DWIDTH     = 16,
   parameter int AWIDTH     = 12,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_in,
   output logic [AWIDTH-1:0] rom_addr,
   output logic              rom_rd,
   input  logic [DWIDTH-1:0] rom_data,
   input  logic              redirect,
   input  logic [AWIDTH-1:0] redirect_addr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DWIDTH-1:0] instr,
   output logic [AWIDTH-1:0] instr_pc
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int OW = PW + 1;
   localparam logic [OW:0] DEPTH_C = (OW+1)'(FIFO_DEPTH);

   logic [AWIDTH-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
   logic              inflight_q, inflight_d;
   logic [OW-1:0]     occ_q, occ_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH-1:0][DWIDTH-1:0] instr_mem_q, instr_mem_d;
   logic [FIFO_DEPTH-1:0][AWIDTH-1:0] pc_mem_q, pc_mem_d;
   logic              pop, push;
   logic [OW:0]       credit;

   assign instr_valid = (occ_q != '0);
   assign pop         = instr_valid & instr_ready;
   // Words already owed to the FIFO after this cycle's pop; never exceeds its depth.
   assign credit      = {1'b0, occ_q} + (OW+1)'(inflight_q) - (OW+1)'(pop);
   assign rom_rd      = ~rst & en_in & ~redirect & (credit < DEPTH_C);
   assign rom_addr    = pc_q;
   assign instr       = instr_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q]    : '0;

   always_comb begin
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = rom_rd;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      instr_mem_d   = instr_mem_q;
      pc_mem_d      = pc_mem_q;
      push          = inflight_q & ~redirect;
      if (rom_rd) begin
         pc_d          = pc_q + AWIDTH'(1);
         inflight_pc_d = pc_q;
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) begin
         instr_mem_d[wr_ptr_q] = rom_data;
         pc_mem_d[wr_ptr_q]    = inflight_pc_q;
         wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      occ_d = occ_q + OW'(push) - OW'(pop);
      // Redirect wins: the popped word is already owned downstream, the rest is dropped.
      if (redirect) begin
         occ_d    = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         pc_d     = redirect_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         occ_q         <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         instr_mem_q   <= '0;
         pc_mem_q      <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         occ_q         <= occ_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         instr_mem_q   <= instr_mem_d;
         pc_mem_q      <= pc_mem_d;
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle table, hand sequences for enable gating and async
// reset, then randomized traffic against an outstanding-word queue model.
module tb_instr_fetch;
   localparam int DW = 16;
   localparam int AW = 12;
   localparam int D  = 2;

   logic          clk, rst, en_in, redirect, instr_ready;
   logic [AW-1:0] redirect_addr, rom_addr, instr_pc;
   logic [DW-1:0] rom_data, instr;
   logic          rom_rd, instr_valid;

   int n_chk = 0;
   int n_fail = 0;

   instr_fetch #(.DWIDTH(DW), .AWIDTH(AW), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .en_in(en_in), .rom_addr(rom_addr), .rom_rd(rom_rd),
      .rom_data(rom_data), .redirect(redirect), .redirect_addr(redirect_addr),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM: mem[k] = 16'h1000 + k, one-cycle read latency
   always @(posedge clk) rom_data <= 16'h1000 + {4'h0, rom_addr};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en_in = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   typedef struct {
      logic          en, rdy, redir;
      logic [AW-1:0] raddr;
      logic          exp_v;
      logic [AW-1:0] exp_pc;
      logic          exp_rd;
      logic [AW-1:0] exp_addr;
   } vec_t;

   vec_t tbl[25];

   function automatic vec_t mk(logic en, logic rdy, logic redir, logic [AW-1:0] raddr,
                               logic v, logic [AW-1:0] pc, logic rd, logic [AW-1:0] addr);
      vec_t t;
      t.en = en; t.rdy = rdy; t.redir = redir; t.raddr = raddr;
      t.exp_v = v; t.exp_pc = pc; t.exp_rd = rd; t.exp_addr = addr;
      return t;
   endfunction

   typedef struct {
      logic [AW-1:0] pc;
      int            cyc;
   } ent_t;

   initial begin
      ent_t          q[$];
      ent_t          e;
      logic [AW-1:0] exp_issue;
      logic          pop, exp_rd;

      // streaming, backpressure at cycles 4..8, redirect to 0A0, wrap via redirect to FFE
      tbl[0]  = mk(1,1,0,12'h000, 0,12'h000,1,12'h000);
      tbl[1]  = mk(1,1,0,12'h000, 0,12'h000,1,12'h001);
      tbl[2]  = mk(1,1,0,12'h000, 1,12'h000,1,12'h002);
      tbl[3]  = mk(1,1,0,12'h000, 1,12'h001,1,12'h003);
      for (int i = 4; i <= 8; i++) tbl[i] = mk(1,0,0,12'h000, 1,12'h002,0,12'h004);
      tbl[9]  = mk(1,1,0,12'h000, 1,12'h002,1,12'h004);
      tbl[10] = mk(1,1,0,12'h000, 1,12'h003,1,12'h005);
      tbl[11] = mk(1,1,0,12'h000, 1,12'h004,1,12'h006);
      tbl[12] = mk(1,1,0,12'h000, 1,12'h005,1,12'h007);
      tbl[13] = mk(1,1,1,12'h0A0, 1,12'h006,0,12'h008);
      tbl[14] = mk(1,1,0,12'h000, 0,12'h000,1,12'h0A0);
      tbl[15] = mk(1,1,0,12'h000, 0,12'h000,1,12'h0A1);
      tbl[16] = mk(1,1,0,12'h000, 1,12'h0A0,1,12'h0A2);
      tbl[17] = mk(1,1,0,12'h000, 1,12'h0A1,1,12'h0A3);
      tbl[18] = mk(1,1,1,12'hFFE, 1,12'h0A2,0,12'h0A4);
      tbl[19] = mk(1,1,0,12'h000, 0,12'h000,1,12'hFFE);
      tbl[20] = mk(1,1,0,12'h000, 0,12'h000,1,12'hFFF);
      tbl[21] = mk(1,1,0,12'h000, 1,12'hFFE,1,12'h000);
      tbl[22] = mk(1,1,0,12'h000, 1,12'hFFF,1,12'h001);
      tbl[23] = mk(1,1,0,12'h000, 1,12'h000,1,12'h002);
      tbl[24] = mk(1,1,0,12'h000, 1,12'h001,1,12'h003);

      rst = 1'b1; en_in = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_addr = '0;
      #1;
      chk("reset_rom_rd", rom_rd, 0);
      chk("reset_rom_addr", rom_addr, 0);
      chk("reset_valid", instr_valid, 0);
      chk("reset_instr", instr, 0);
      chk("reset_instr_pc", instr_pc, 0);

      do_reset();
      for (int i = 0; i < 25; i++) begin
         en_in = tbl[i].en; instr_ready = tbl[i].rdy;
         redirect = tbl[i].redir; redirect_addr = tbl[i].raddr;
         @(negedge clk);
         chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].exp_v);
         chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].exp_v ? tbl[i].exp_pc : 12'h000);
         chk($sformatf("tbl%0d_instr", i), instr,
             tbl[i].exp_v ? 16'h1000 + {4'h0, tbl[i].exp_pc} : 16'h0000);
         chk($sformatf("tbl%0d_rom_rd", i), rom_rd, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_rom_addr", i), rom_addr, tbl[i].exp_addr);
         step();
      end
      redirect = 1'b0;

      // enable gating: drop en_in once pc 5 has been issued
      do_reset();
      en_in = 1'b1; instr_ready = 1'b1;
      repeat (6) step();
      en_in = 1'b0;
      @(negedge clk);
      chk("gate_c6_rom_rd", rom_rd, 0);
      chk("gate_c6_pc", instr_pc, 12'h004);
      step();
      @(negedge clk);
      chk("gate_c7_valid", instr_valid, 1);
      chk("gate_c7_pc", instr_pc, 12'h005);
      chk("gate_c7_rom_rd", rom_rd, 0);
      step();
      @(negedge clk);
      chk("gate_c8_valid", instr_valid, 0);
      chk("gate_c8_instr", instr, 0);
      chk("gate_c8_pc", instr_pc, 0);
      step();
      en_in = 1'b1;
      @(negedge clk);
      chk("gate_resume_rom_rd", rom_rd, 1);
      chk("gate_resume_addr", rom_addr, 12'h006);
      step(); step();
      @(negedge clk);
      chk("gate_resume_pc", instr_pc, 12'h006);
      chk("gate_resume_instr", instr, 16'h1006);

      // asynchronous reset between clock edges, mid-stream
      step(); step();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", instr_valid, 0);
      chk("arst_instr", instr, 0);
      chk("arst_pc", instr_pc, 0);
      chk("arst_rom_rd", rom_rd, 0);
      chk("arst_rom_addr", rom_addr, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("arst_c0_rom_rd", rom_rd, 1);
      chk("arst_c0_addr", rom_addr, 0);
      chk("arst_c0_valid", instr_valid, 0);
      step(); step();
      @(negedge clk);
      chk("arst_c2_valid", instr_valid, 1);
      chk("arst_c2_pc", instr_pc, 0);
      chk("arst_c2_instr", instr, 16'h1000);

      // randomized traffic against a queue of issued-but-undelivered words
      do_reset();
      exp_issue = '0;
      q.delete();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         en_in       = ($urandom_range(0, 9) != 0);
         instr_ready = ($urandom_range(0, 9) < 7);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(4093, 4095))
                                                     : AW'($urandom_range(0, 4095));
         @(negedge clk);
         pop = instr_valid & instr_ready;
         if (!instr_valid) begin
            chk("rnd_empty_instr", instr, 0);
            chk("rnd_empty_pc", instr_pc, 0);
         end
         if (q.size() > 0 && q[0].cyc <= cyc - 2)
            chk("rnd_latency_valid", instr_valid, 1);
         if (pop) begin
            chk("rnd_pop_has_word", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("rnd_pc", instr_pc, e.pc);
               chk("rnd_instr", instr, 16'h1000 + {4'h0, e.pc});
            end
         end
         exp_rd = en_in && !redirect && (q.size() < D);
         chk("rnd_rom_rd", rom_rd, exp_rd);
         if (rom_rd) begin
            chk("rnd_rom_addr", rom_addr, exp_issue);
            e.pc = exp_issue; e.cyc = cyc;
            q.push_back(e);
            exp_issue = exp_issue + 1'b1;
         end
         if (redirect) begin
            q.delete();
            exp_issue = redirect_addr;
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
